// File: rtl/persp_div_seq_if.sv
// Vertex input, divider request/response and screen-result handshake bundle.
// The master modport is the sequencer's view; slave is the environment's view.
interface persp_div_seq_if;
  // Vertex input handshake
  logic        in_valid;
  logic        in_ready;
  logic [10:0] in_x;
  logic [10:0] in_y;
  logic [19:0] in_z;
  // Shared divider
  logic [19:0] div_dividend;
  logic [19:0] div_divisor;
  logic        div_start;
  logic        div_done;
  logic [19:0] div_quotient;
  // Result handshake
  logic        out_valid;
  logic        out_ready;
  logic [12:0] out_sx;
  logic [12:0] out_sy;
  logic        out_clip;
  logic        out_offscreen;

  modport master (
    input  in_valid, in_x, in_y, in_z, div_done, div_quotient, out_ready,
    output in_ready, div_dividend, div_divisor, div_start,
           out_valid, out_sx, out_sy, out_clip, out_offscreen
  );

  modport slave (
    output in_valid, in_x, in_y, in_z, div_done, div_quotient, out_ready,
    input  in_ready, div_dividend, div_divisor, div_start,
           out_valid, out_sx, out_sy, out_clip, out_offscreen
  );
endinterface

// File: rtl/persp_div_seq.sv
// Perspective-projection sequencer: two divides (|x|*F/z, |y|*F/z) through one
// shared divider, then sign, screen-centre offset, saturation and offscreen flag.
module persp_div_seq #(
  parameter int unsigned FOCAL = 256,
  parameter int unsigned CX    = 320,
  parameter int unsigned CY    = 240,
  parameter int unsigned SCR_W = 640,
  parameter int unsigned SCR_H = 480,
  parameter int unsigned QSAT  = 2047
) (
  input logic            clk,
  input logic            rst,
  persp_div_seq_if.master bus
);

  typedef enum logic [2:0] {
    StIdle, StXIssue, StXWait, StYIssue, StYWait, StCompute, StOut
  } state_e;

  localparam logic signed [12:0] CxS   = 13'(CX);
  localparam logic signed [12:0] CyS   = 13'(CY);
  localparam logic signed [12:0] ScrWS = 13'(SCR_W);
  localparam logic signed [12:0] ScrHS = 13'(SCR_H);

  state_e state_q, state_d;

  logic [10:0]        xmag_q, ymag_q;
  logic               xneg_q, yneg_q;
  logic [19:0]        z_q;
  logic [11:0]        qx_q, qy_q;
  logic signed [12:0] sx_q, sy_q;
  logic               clip_q, off_q;

  logic [10:0]        in_xmag, in_ymag;
  logic [11:0]        q_sat;
  logic signed [12:0] qx_s, qy_s;
  logic signed [12:0] sx_calc, sy_calc;
  logic               off_calc;

  // Magnitudes of the incoming coordinates (-1024 maps to 1024 as unsigned)
  always_comb begin
    in_xmag = bus.in_x[10] ? 11'(-bus.in_x) : bus.in_x;
    in_ymag = bus.in_y[10] ? 11'(-bus.in_y) : bus.in_y;
    q_sat   = (bus.div_quotient > 20'(QSAT)) ? 12'(QSAT) : bus.div_quotient[11:0];
  end

  // Screen-space arithmetic for the COMPUTE cycle
  always_comb begin
    qx_s     = {1'b0, qx_q};
    qy_s     = {1'b0, qy_q};
    sx_calc  = CxS + (xneg_q ? -qx_s : qx_s);
    sy_calc  = CyS - (yneg_q ? -qy_s : qy_s);
    off_calc = sx_calc[12] || (sx_calc >= ScrWS) || sy_calc[12] || (sy_calc >= ScrHS);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; div_done is only looked at in the WAIT states, so a stale
  // done arriving while idle or issuing is ignored.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (bus.in_valid) state_d = (bus.in_z == '0) ? StOut : StXIssue;
      StXIssue:  state_d = StXWait;
      StXWait:   if (bus.div_done) state_d = StYIssue;
      StYIssue:  state_d = StYWait;
      StYWait:   if (bus.div_done) state_d = StCompute;
      StCompute: state_d = StOut;
      StOut:     if (bus.out_ready) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Outputs decoded from state; divider operands held through each WAIT
  always_comb begin
    bus.in_ready     = (state_q == StIdle);
    bus.out_valid    = (state_q == StOut);
    bus.div_start    = (state_q == StXIssue) || (state_q == StYIssue);
    bus.div_dividend = '0;
    bus.div_divisor  = '0;
    if ((state_q == StXIssue) || (state_q == StXWait)) begin
      bus.div_dividend = 20'(xmag_q) * 20'(FOCAL);
      bus.div_divisor  = z_q;
    end else if ((state_q == StYIssue) || (state_q == StYWait)) begin
      bus.div_dividend = 20'(ymag_q) * 20'(FOCAL);
      bus.div_divisor  = z_q;
    end
    bus.out_sx        = sx_q;
    bus.out_sy        = sy_q;
    bus.out_clip      = clip_q;
    bus.out_offscreen = off_q;
  end

  // Datapath registers: vertex latch, quotient capture, result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xmag_q <= '0;
      ymag_q <= '0;
      xneg_q <= 1'b0;
      yneg_q <= 1'b0;
      z_q    <= '0;
      qx_q   <= '0;
      qy_q   <= '0;
      sx_q   <= '0;
      sy_q   <= '0;
      clip_q <= 1'b0;
      off_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            xmag_q <= in_xmag;
            ymag_q <= in_ymag;
            xneg_q <= bus.in_x[10];
            yneg_q <= bus.in_y[10];
            z_q    <= bus.in_z;
            if (bus.in_z == '0) begin
              sx_q   <= CxS;
              sy_q   <= CyS;
              clip_q <= 1'b1;
              off_q  <= 1'b1;
            end
          end
        end
        StXWait: if (bus.div_done) qx_q <= q_sat;
        StYWait: if (bus.div_done) qy_q <= q_sat;
        StCompute: begin
          sx_q   <= sx_calc;
          sy_q   <= sy_calc;
          clip_q <= 1'b0;
          off_q  <= off_calc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_persp_div_seq.sv
// Scoreboard bench for persp_div_seq with a behavioural variable-latency divider.
module tb_persp_div_seq;
  logic clk = 1'b0;
  logic rst;

  persp_div_seq_if bus();

  persp_div_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sx;
    int sy;
    int clip;
    int off;
    int starts;
  } exp_t;

  exp_t sb[$];
  int checks    = 0;
  int failures  = 0;
  int start_cnt = 0;
  int fixed_lat = 0;

  logic [19:0] dd, dv;
  int lat;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, int'(bus.in_ready), 1);
    chk({tag, "_div_start"}, int'(bus.div_start), 0);
    chk({tag, "_dividend"}, int'(bus.div_dividend), 0);
    chk({tag, "_divisor"}, int'(bus.div_divisor), 0);
    chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
    chk({tag, "_out_sx"}, int'($signed(bus.out_sx)), 0);
    chk({tag, "_out_sy"}, int'($signed(bus.out_sy)), 0);
    chk({tag, "_out_clip"}, int'(bus.out_clip), 0);
    chk({tag, "_out_off"}, int'(bus.out_offscreen), 0);
  endtask

  // Called at posedge+1; returns one cycle after the accepting edge
  task automatic send(input int x, input int y, input int z,
                      input int sx, input int sy, input int clip, input int off);
    int n = 0;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.in_ready) chk("in_ready_timeout", 0, 1);
    sb.push_back('{sx, sy, clip, off, (clip != 0) ? 0 : 2});
    bus.in_valid = 1'b1;
    bus.in_x     = 11'(x);
    bus.in_y     = 11'(y);
    bus.in_z     = 20'(z);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) chk({name, "_drain_timeout"}, sb.size(), 0);
  endtask

  // Behavioural divider: fixed or random latency from div_start to done
  initial begin
    bus.div_done     = 1'b0;
    bus.div_quotient = '0;
    forever begin
      @(negedge clk);
      if (bus.div_start && !rst) begin
        dd  = bus.div_dividend;
        dv  = bus.div_divisor;
        lat = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(2, 5));
        repeat (lat) @(posedge clk);
        #1;
        bus.div_quotient = (dv == '0) ? '1 : dd / dv;
        bus.div_done     = 1'b1;
        @(posedge clk);
        #1;
        bus.div_done = 1'b0;
      end
    end
  end

  // Monitor: counts divider launches and checks each accepted result
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        start_cnt = 0;
      end else begin
        if (bus.div_start) start_cnt++;
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("out_sx", int'($signed(bus.out_sx)), e.sx);
            chk("out_sy", int'($signed(bus.out_sy)), e.sy);
            chk("out_clip", int'(bus.out_clip), e.clip);
            chk("out_offscreen", int'(bus.out_offscreen), e.off);
            chk("div_start_count", start_cnt, e.starts);
          end
          start_cnt = 0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.in_z      = '0;
    bus.out_ready = 1'b1;
    #1;
    chk_reset_vals("por");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    send(100, 50, 200, 448, 176, 0, 0);       drain("pos");
    send(-100, -50, 200, 192, 304, 0, 0);     drain("neg");
    send(7, 9, 0, 320, 240, 1, 1);
    @(negedge clk);
    chk("clip_latency_out_valid", int'(bus.out_valid), 1);
    drain("clip");
    send(1000, 0, 1, 2367, 240, 0, 1);        drain("sat");
    send(-1024, -1024, 1024, 64, 496, 0, 1);  drain("minneg");
    send(0, 0, 5, 320, 240, 0, 0);            drain("zero");
    send(320, 240, 256, 640, 0, 0, 1);        drain("edge_off");

    // Backpressure: result held for 10 cycles
    bus.out_ready = 1'b0;
    send(319, 239, 256, 639, 1, 0, 0);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("hold_wait_valid", int'(bus.out_valid), 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_sx", int'($signed(bus.out_sx)), 639);
      chk("hold_sy", int'($signed(bus.out_sy)), 1);
      chk("hold_flags", int'({bus.out_clip, bus.out_offscreen}), 0);
      chk("hold_valid", int'(bus.out_valid), 1);
      chk("hold_in_ready", int'(bus.in_ready), 0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_out_valid", int'(bus.out_valid), 0);
    chk("release_in_ready", int'(bus.in_ready), 1);
    drain("hold");

    // Reset during X_WAIT; the divider's late done lands while idle
    fixed_lat = 5;
    send(100, 50, 200, 448, 176, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_reset_vals("midreset");
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("stale_in_ready", int'(bus.in_ready), 1);
    chk("stale_out_valid", int'(bus.out_valid), 0);
    chk("stale_div_start", int'(bus.div_start), 0);
    fixed_lat = 0;
    send(100, 50, 200, 448, 176, 0, 0);       drain("post_reset");

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
